rtc_hms_core: RTL and testbench
===============================

Name: rtc_hms_core

Overview:
- Parametrised hours/minutes/seconds timekeeping core with integrated set-mode FSM and six-digit 7-segment display encoding.
- Successor to the fixed-frequency, 24-hour-only clock top. Adds:
  - generic input clock frequency;
  - runtime 12/24-hour display mode;
  - increment and decrement setting;
  - blinking of the field being set.
- Sits directly between the board clock/keys and the HEX5..HEX0 displays.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; one-second prescaler terminal count is CLK_HZ-1.
- BLINK_HZ, 2, blink rate of the selected field in set mode; blink phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- K_mode  in  1  key, active-low, asynchronous to the clock; advances the FSM.
- K_inc  in  1  key, active-low; increments the selected field.
- K_dec  in  1  key, active-low; decrements the selected field.
- mode24  in  1  1 = 24-hour display, 0 = 12-hour display (quasi-static).
- HEX5..HEX0  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX5/4 hours, HEX3/2 minutes, HEX1/0 seconds.
- hh, mm, ss  out  6 each  binary time; hh is always 0-23 internally.
- pm  out  1  1 when hh >= 12, independent of mode24.
- state  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
- sec_pulse  out  1  one-cycle strobe on each second tick.

Behaviour:
- **Key handling**
  - Each key passes through a 2-flop synchroniser, then falling-edge detection: one event per press, 3-cycle latency from pin to action.
  - Holding a key produces no repeat.
- **Reset** (reset=0 at a clock edge, any state, mid-count included):
  - hh=mm=ss=0, state=RUN, prescaler=0, blink phase=visible, sec_pulse=0, synchroniser flops=1.
- **Prescaler**
  - Counts 0..CLK_HZ-1 in RUN only.
  - At the terminal count: sec_pulse=1 for that cycle and the time advances.
- **Time advance**, all in the same cycle:
  - ss 59→0 with mm+1;
  - mm 59→0 with hh+1;
  - hh 23→0.
  - 23:59:59 → 00:00:00 in one tick.
- **FSM**
  - A K_mode event moves RUN→SET_H→SET_M→SET_S→RUN.
  - Entering any SET state holds the prescaler at 0 and suppresses sec_pulse.
  - SET_S→RUN restarts the prescaler from 0, so the first tick comes CLK_HZ cycles later.
- **Setting**
  - In SET_x, a K_inc event increments the selected field with wrap (hh 23→0, mm/ss 59→0); a K_dec event decrements it (0→23 or 0→59).
  - No carry into neighbouring fields.
  - K_inc and K_dec in RUN are ignored.
- **Simultaneous events**
  - K_mode with K_inc/K_dec in the same cycle: mode wins, and the adjust is discarded.
  - K_inc and K_dec in the same cycle: both ignored.
- **Blink**
  - The blink counter runs continuously; the phase toggles at the terminal count.
  - In SET_x during the off-phase, the selected field's two HEX outputs are 7'b1111111.
  - On each state change the phase resets to visible and the counter to 0.
- **Display**
  - HEX outputs are combinational from the registered hh/mm/ss/state/phase, so there is zero extra latency.
  - 24-hour mode: hh shown as two decimal digits.
  - 12-hour mode: hh 0→12, 13..23→1..11; the hours tens digit is blanked when it is zero.
  - Digit encoding, active-low:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **mode24 changes** affect only the display, never the stored time.

Test Plan:
- Reset, 24h: CLK_HZ=10, mode24=1, hold reset=0 for 2 cycles → all HEX=1000000, state=0. After 10 cycles of reset=1 → sec_pulse=1 once and HEX0=1111001.
- Rollover: set hh=23, mm=59, ss=58 via SET states, return to RUN, run 20 cycles → display 00:00:00 and pm falls 1→0.
- Set mode: K_mode press → state=1. Two K_inc presses then one K_dec → hh=1. No sec_pulse while in SET. K_dec at hh=0 → hh=23.
- Blink: BLINK_HZ=1, CLK_HZ=10, state=SET_M → HEX3/HEX2 alternate between digits and 1111111 every 5 cycles; other digits stay steady.
- 12h mode: hh=0 with mode24=0 → HEX5=1111001, HEX4=0100100. hh=13 → HEX5=1111111, HEX4=1111001, pm=1.
- Collisions: K_mode and K_inc falling in the same cycle in SET_H → state=2 and hh unchanged. K_inc and K_dec together → no change. Reset asserted mid-SET_M → state=0, time 00:00:00.

Source files
------------

// File: rtl/rtc_hms_core.sv
// Hours/minutes/seconds timekeeping core with key-driven set mode, field blink
// and six-digit active-low 7-segment output (12/24-hour display).
//
// state | meaning
// RUN   | time advances once per second
// SET_H | hours adjustable, prescaler held at 0
// SET_M | minutes adjustable, prescaler held at 0
// SET_S | seconds adjustable, prescaler held at 0
module rtc_hms_core #(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       K_mode,
  input  logic       K_inc,
  input  logic       K_dec,
  input  logic       mode24,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [5:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       pm,
  output logic [1:0] state,
  output logic       sec_pulse
);

  localparam int PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLINK_N_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_N     = (BLINK_N_RAW < 1) ? 1 : BLINK_N_RAW;
  localparam int BW          = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_N - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} st_e;

  // key vectors are {mode, inc, dec}
  logic [2:0]    key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  logic [2:0]    key_ev;
  st_e           state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [5:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic          mode_ev, adj_ok, inc_ev, dec_ev, tick;

  always_comb begin
    key_s1_d   = {K_mode, K_inc, K_dec};
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    key_ev     = key_prev_q & ~key_s2_q;
    mode_ev    = key_ev[2];
    // adjust is dropped on a mode collision or when inc and dec coincide
    adj_ok     = (state_q != RUN) && !mode_ev && (key_ev[1] ^ key_ev[0]);
    inc_ev     = adj_ok && key_ev[1];
    dec_ev     = adj_ok && key_ev[0];
    tick       = (state_q == RUN) && (presc_q == PRE_TC);

    state_d = mode_ev ? st_e'(state_q + 2'd1) : state_q;

    if ((state_q == RUN) && !mode_ev)
      presc_d = tick ? '0 : presc_q + PW'(1);
    else
      presc_d = '0;

    if (mode_ev) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_off_d = blink_off_q;
    end

    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (tick) begin
      if (ss_q == 6'd59) begin
        ss_d = 6'd0;
        if (mm_q == 6'd59) begin
          mm_d = 6'd0;
          hh_d = (hh_q == 6'd23) ? 6'd0 : hh_q + 6'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end else if (inc_ev) begin
      case (state_q)
        SET_H:   hh_d = (hh_q == 6'd23) ? 6'd0 : hh_q + 6'd1;
        SET_M:   mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        SET_S:   ss_d = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
        default: ;
      endcase
    end else if (dec_ev) begin
      case (state_q)
        SET_H:   hh_d = (hh_q == 6'd0) ? 6'd23 : hh_q - 6'd1;
        SET_M:   mm_d = (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
        SET_S:   ss_d = (ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      key_s1_q    <= 3'b111;
      key_s2_q    <= 3'b111;
      key_prev_q  <= 3'b111;
      state_q     <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      hh_q        <= 6'd0;
      mm_q        <= 6'd0;
      ss_q        <= 6'd0;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_prev_q  <= key_prev_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      tens_of = 4'd5;
    else if (v >= 6'd40) tens_of = 4'd4;
    else if (v >= 6'd30) tens_of = 4'd3;
    else if (v >= 6'd20) tens_of = 4'd2;
    else if (v >= 6'd10) tens_of = 4'd1;
    else                 tens_of = 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] r;
    r = v - ({2'b00, tens_of(v)} * 6'd10);
    ones_of = r[3:0];
  endfunction

  logic [5:0] h_disp;
  logic [3:0] h_tens;
  logic       blank_h, blank_m, blank_s, blank_ht;

  always_comb begin
    if (mode24)             h_disp = hh_q;
    else if (hh_q == 6'd0)  h_disp = 6'd12;
    else if (hh_q > 6'd12)  h_disp = hh_q - 6'd12;
    else                    h_disp = hh_q;
    h_tens   = tens_of(h_disp);
    blank_ht = !mode24 && (h_tens == 4'd0);
    blank_h  = blink_off_q && (state_q == SET_H);
    blank_m  = blink_off_q && (state_q == SET_M);
    blank_s  = blink_off_q && (state_q == SET_S);

    HEX5 = (blank_h || blank_ht) ? SEG_OFF : seg7(h_tens);
    HEX4 = blank_h ? SEG_OFF : seg7(ones_of(h_disp));
    HEX3 = blank_m ? SEG_OFF : seg7(tens_of(mm_q));
    HEX2 = blank_m ? SEG_OFF : seg7(ones_of(mm_q));
    HEX1 = blank_s ? SEG_OFF : seg7(tens_of(ss_q));
    HEX0 = blank_s ? SEG_OFF : seg7(ones_of(ss_q));
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign pm        = (hh_q >= 6'd12);
  assign state     = state_q;
  assign sec_pulse = tick;

endmodule

// File: tb/tb_rtc_hms_core.sv
// Directed bench for rtc_hms_core with CLK_HZ=10, BLINK_HZ=1: table-driven key
// sequences plus hand-written reset, blink, rollover, 12h and collision cases.
module tb_rtc_hms_core;

  logic       CLOCK_50 = 1'b0;
  logic       reset, K_mode, K_inc, K_dec, mode24;
  logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [5:0] hh, mm, ss;
  logic       pm, sec_pulse;
  logic [1:0] state;

  rtc_hms_core #(.CLK_HZ(10), .BLINK_HZ(1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .K_mode(K_mode), .K_inc(K_inc),
    .K_dec(K_dec), .mode24(mode24),
    .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .state(state), .sec_pulse(sec_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic       m, i, d;
    logic [1:0] st;
    logic [5:0] h, mi, s;
    string      name;
  } row_t;

  row_t rows[12];
  int   total = 0;
  int   bad = 0;
  int   set_pulses = 0;
  int   pulses;

  always @(negedge CLOCK_50)
    if (reset === 1'b1 && state != 2'd0 && sec_pulse) set_pulses++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // keys go low at a falling edge; the action lands on the third rising edge
  task automatic press(input logic m, input logic i, input logic d);
    K_mode = ~m;
    K_inc  = ~i;
    K_dec  = ~d;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic release_keys();
    K_mode = 1'b1;
    K_inc  = 1'b1;
    K_dec  = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic apply_row(input int n);
    press(rows[n].m, rows[n].i, rows[n].d);
    chk({rows[n].name, "_state"}, state, rows[n].st);
    chk({rows[n].name, "_hh"}, hh, rows[n].h);
    chk({rows[n].name, "_mm"}, mm, rows[n].mi);
    chk({rows[n].name, "_ss"}, ss, rows[n].s);
    release_keys();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 6'd0,  6'd0,  6'd1,  "enter_seth"};
    rows[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 6'd1,  6'd0,  6'd1,  "inc_h1"};
    rows[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 6'd2,  6'd0,  6'd1,  "inc_h2"};
    rows[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 6'd1,  6'd0,  6'd1,  "dec_h1"};
    rows[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 6'd0,  6'd0,  6'd1,  "dec_h0"};
    rows[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 6'd23, 6'd0,  6'd1,  "dec_h_wrap"};
    rows[6]  = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd23, 6'd0,  6'd1,  "inc_dec_h"};
    rows[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 6'd23, 6'd59, 6'd1,  "dec_m_wrap"};
    rows[8]  = '{1'b1, 1'b0, 1'b0, 2'd3, 6'd23, 6'd59, 6'd1,  "enter_sets"};
    rows[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, 6'd23, 6'd59, 6'd0,  "dec_s0"};
    rows[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 6'd23, 6'd59, 6'd59, "dec_s_wrap"};
    rows[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 6'd23, 6'd59, 6'd58, "dec_s58"};

    reset = 1'b0; K_mode = 1'b1; K_inc = 1'b1; K_dec = 1'b1; mode24 = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_state", state, 0);
    chk("rst_hex5", HEX5, S0);
    chk("rst_hex3", HEX3, S0);
    chk("rst_hex0", HEX0, S0);
    chk("rst_time", {hh, mm, ss}, 0);
    chk("rst_pulse", sec_pulse, 0);

    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (sec_pulse) pulses++;
    end
    chk("first_sec_pulses", pulses, 1);
    chk("first_sec_hex0", HEX0, S1);
    chk("first_sec_ss", ss, 1);

    for (int n = 0; n < 7; n++) apply_row(n);

    // entering SET_M restarts the blink phase: 5 cycles visible, 5 blanked
    press(1'b1, 1'b0, 1'b0);
    chk("blink_state", state, 2);
    for (int k = 0; k < 10; k++) begin
      chk("blink_hex3", HEX3, (k >= 5) ? SB : S0);
      chk("blink_hex2", HEX2, (k >= 5) ? SB : S0);
      chk("blink_hex5", HEX5, S2);
      chk("blink_hex0", HEX0, S1);
      @(negedge CLOCK_50);
    end
    release_keys();

    for (int n = 7; n < 12; n++) apply_row(n);

    press(1'b1, 1'b0, 1'b0);
    K_mode = 1'b1;
    chk("roll_state", state, 0);
    chk("roll_pre", {hh, mm, ss}, {6'd23, 6'd59, 6'd58});
    chk("roll_pm_pre", pm, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (sec_pulse) pulses++;
    end
    chk("roll_pulses", pulses, 2);
    chk("roll_time", {hh, mm, ss}, 0);
    chk("roll_pm_post", pm, 0);
    chk("roll_hex5", HEX5, S0);
    chk("roll_hex4", HEX4, S0);
    chk("roll_hex2", HEX2, S0);
    chk("roll_hex0", HEX0, S0);

    mode24 = 1'b0;
    #1;
    chk("h12_zero_hex5", HEX5, S1);
    chk("h12_zero_hex4", HEX4, S2);
    chk("h12_zero_hh", hh, 0);

    press(1'b0, 1'b1, 1'b0);
    release_keys();
    chk("run_inc_state", state, 0);
    chk("run_inc_hh", hh, 0);
    chk("run_inc_mm", mm, 0);

    press(1'b1, 1'b0, 1'b0);
    release_keys();
    chk("seth_again", state, 1);
    for (int k = 0; k < 11; k++) begin
      press(1'b0, 1'b0, 1'b1);
      release_keys();
    end
    chk("set_h13", hh, 13);

    press(1'b1, 1'b0, 1'b0);
    chk("h12_13_hex5", HEX5, SB);
    chk("h12_13_hex4", HEX4, S1);
    chk("h12_13_pm", pm, 1);
    release_keys();
    mode24 = 1'b1;
    #1;
    chk("h24_13_hex5", HEX5, S1);
    chk("h24_13_hex4", HEX4, S3);
    chk("h24_13_hh", hh, 13);

    for (int k = 0; k < 3; k++) begin
      press(1'b1, 1'b0, 1'b0);
      release_keys();
    end
    chk("back_to_seth", state, 1);
    press(1'b1, 1'b1, 1'b0);
    chk("coll_mode_state", state, 2);
    chk("coll_mode_hh", hh, 13);
    release_keys();
    press(1'b0, 1'b1, 1'b1);
    release_keys();
    chk("coll_incdec_mm", mm, 0);
    chk("coll_incdec_state", state, 2);

    reset = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("midset_rst_state", state, 0);
    chk("midset_rst_time", {hh, mm, ss}, 0);
    chk("midset_rst_hex5", HEX5, S0);
    reset = 1'b1;
    @(negedge CLOCK_50);

    chk("no_pulse_in_set", set_pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
